// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer around an external DW-bit adder.
// Words arrive least-significant first, and the carry chains across the words through carry_q.
module wide_add_seq #(
    parameter int WORDS = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_sub,
    output logic [DW-1:0] add_x,
    output logic [DW-1:0] add_y,
    output logic          add_cin,
    input  logic [DW-1:0] add_s,
    input  logic          add_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_sum,
    output logic          out_last,
    output logic          out_carry,
    output logic          out_ovf,
    output logic          out_zero
);

    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    logic [CW-1:0] r_wcnt;
    logic          r_sub;
    logic          r_carry;
    logic          r_zacc;

    logic [DW-1:0] r_x_p1;
    logic [DW-1:0] r_y_p1;
    logic          r_first_p1;
    logic          r_last_p1;
    logic          r_vld_p1;

    logic [DW-1:0] r_sum_p2;
    logic          r_last_p2;
    logic          r_carry_p2;
    logic          r_ovf_p2;
    logic          r_zero_p2;
    logic          r_vld_p2;

    logic w_adv1;
    logic w_adv2;
    logic w_accept;
    logic w_xfer;
    logic w_first;
    logic w_last;
    logic w_sub_eff;
    logic w_zval;
    logic w_ovf;

    always_comb begin
        w_adv2    = !r_vld_p2 || out_ready;
        w_adv1    = !r_vld_p1 || w_adv2;
        w_accept  = in_valid && w_adv1;
        w_xfer    = r_vld_p1 && w_adv2;
        w_first   = (r_wcnt == '0);
        w_last    = (r_wcnt == LAST_IDX);
        w_sub_eff = w_first ? in_sub : r_sub;
        w_zval    = (r_first_p1 ? 1'b1 : r_zacc) && (add_s == '0);
        w_ovf     = (r_x_p1[DW-1] == r_y_p1[DW-1]) && (add_s[DW-1] != r_x_p1[DW-1]);
    end

    assign in_ready = w_adv1;
    assign add_x    = r_x_p1;
    assign add_y    = r_y_p1;
    assign add_cin  = r_first_p1 ? r_sub : r_carry;

    // ---- stage p1: operand capture (B pre-inverted for subtract) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1   <= 1'b0;
            r_first_p1 <= 1'b0;
            r_last_p1  <= 1'b0;
            r_wcnt     <= '0;
            r_sub      <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1   <= 1'b1;
            r_first_p1 <= w_first;
            r_last_p1  <= w_last;
            r_wcnt     <= w_last ? '0 : r_wcnt + 1'b1;
            if (w_first) begin
                r_sub <= in_sub;
            end
        end else if (w_adv2) begin
            r_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x_p1 <= in_a;
            r_y_p1 <= w_sub_eff ? ~in_b : in_b;
        end
    end

    // Carry and zero state move only on the p1->p2 transfer, so stalls leave the chain intact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_zacc  <= 1'b0;
        end else if (w_xfer) begin
            r_carry <= r_last_p1 ? 1'b0 : add_cout;
            r_zacc  <= w_zval;
        end
    end

    // ---- stage p2: result capture ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p2   <= 1'b0;
            r_sum_p2   <= '0;
            r_last_p2  <= 1'b0;
            r_carry_p2 <= 1'b0;
            r_ovf_p2   <= 1'b0;
            r_zero_p2  <= 1'b0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_sum_p2   <= add_s;
                r_last_p2  <= r_last_p1;
                r_carry_p2 <= r_last_p1 && add_cout;
                r_ovf_p2   <= r_last_p1 && w_ovf;
                r_zero_p2  <= r_last_p1 && w_zval;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign out_sum   = r_sum_p2;
    assign out_last  = r_last_p2;
    assign out_carry = r_carry_p2;
    assign out_ovf   = r_ovf_p2;
    assign out_zero  = r_zero_p2;

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: models the 32-bit adder and checks each output word
// against a 128-bit arithmetic reference model.
module tb_wide_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [31:0] add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_last;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;

    always #5 clk = ~clk;

    assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    wide_add_seq #(.WORDS(4), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_last(out_last), .out_carry(out_carry),
        .out_ovf(out_ovf), .out_zero(out_zero)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pk(input logic [31:0] s, input logic l, input logic c,
                                       input logic o, input logic z);
        return {s, l, c, o, z};
    endfunction

    // reference model state
    logic [35:0]  exp_q[$];
    logic [35:0]  log_q[$];
    logic [127:0] m_a, m_b;
    logic         m_sub;
    int           m_idx = 0;
    bit           stalled_prev = 0;
    logic [31:0]  prev_sum;
    int           run = 0;
    int           max_run = 0;

    always @(negedge clk) begin
        logic [127:0]        d;
        logic [128:0]        u;
        logic signed [129:0] sa, sb, sr;
        logic                c, o, z, l;

        if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got word %h with no expected word", out_sum);
            end else begin
                chk("out_word", {28'd0, out_sum, out_last, out_carry, out_ovf, out_zero},
                    {28'd0, exp_q[0]});
                if (out_ready) begin
                    log_q.push_back(pk(out_sum, out_last, out_carry, out_ovf, out_zero));
                    void'(exp_q.pop_front());
                end
            end
            if (stalled_prev) chk("stall_hold", {32'd0, out_sum}, {32'd0, prev_sum});
        end
        stalled_prev = out_valid && !out_ready && rst_n;
        prev_sum     = out_sum;
        run          = out_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;

        if (!rst_n) begin
            exp_q.delete();
            m_idx = 0;
        end else if (in_valid && in_ready) begin
            if (m_idx == 0) begin
                m_a   = '0;
                m_b   = '0;
                m_sub = in_sub;
            end
            m_a[m_idx*32 +: 32] = in_a;
            m_b[m_idx*32 +: 32] = in_b;
            d = m_sub ? m_a - m_b : m_a + m_b;
            l = (m_idx == 3);
            c = 1'b0; o = 1'b0; z = 1'b0;
            if (l) begin
                u  = {1'b0, m_a} + {1'b0, m_b};
                c  = m_sub ? (m_a >= m_b) : u[128];
                sa = {{2{m_a[127]}}, m_a};
                sb = {{2{m_b[127]}}, m_b};
                sr = m_sub ? sa - sb : sa + sb;
                o  = (sr[129:127] != {3{sr[127]}});
                z  = (d == '0);
            end
            exp_q.push_back(pk(d[m_idx*32 +: 32], l, c, o, z));
            m_idx = l ? 0 : m_idx + 1;
        end
    end

    task automatic send_word(input logic [31:0] a, input logic [31:0] b, input logic s);
        bit acc = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic send_txn(input logic [127:0] a, input logic [127:0] b, input logic [3:0] s);
        for (int i = 0; i < 4; i++) send_word(a[i*32 +: 32], b[i*32 +: 32], s[i]);
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain", {63'd0, k < 40}, 64'd1);
    endtask

    task automatic chk_log(input string name, input int n, input logic [35:0] e0,
                           input logic [35:0] e1, input logic [35:0] e2, input logic [35:0] e3);
        logic [35:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({name, "_count"}, 64'(log_q.size()), 64'(n));
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk($sformatf("%s_w%0d", name, i), {28'd0, log_q[i]}, {28'd0, e[i]});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outputs", {28'd0, out_sum, out_last, out_carry, out_ovf, out_zero}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // carry ripples across all words
        log_q.delete();
        send_txn(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 4'b0000);
        drain();
        chk_log("t1", 4, pk(0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0),
                pk(32'h1, 1, 0, 0, 0));

        // subtract equal operands; in_sub change on word 2 must be ignored
        log_q.delete();
        send_txn({4{32'h12345678}}, {4{32'h12345678}}, 4'b1011);
        drain();
        chk_log("t2", 4, pk(0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0),
                pk(0, 1, 1, 0, 1));

        // signed overflow
        log_q.delete();
        send_txn(128'h7FFFFFFF_00000000_00000000_00000000,
                 128'h00000001_00000000_00000000_00000000, 4'b0000);
        drain();
        chk_log("t3", 4, pk(0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0),
                pk(32'h80000000, 1, 0, 1, 0));

        // back-to-back transactions, no stale carry into the second
        log_q.delete();
        max_run = 0;
        send_txn({4{32'hFFFFFFFF}}, 128'h1, 4'b0000);
        send_txn(128'h5, 128'h3, 4'b0000);
        drain();
        chk("t4_run", 64'(max_run), 64'd8);
        chk("t4_a_last", {28'd0, log_q[3]}, {28'd0, pk(0, 1, 1, 0, 1)});
        chk("t4_b_w0", {28'd0, log_q[4]}, {28'd0, pk(32'h8, 0, 0, 0, 0)});
        chk("t4_b_last", {28'd0, log_q[7]}, {28'd0, pk(0, 1, 0, 0, 0)});

        // backpressure mid-stream
        log_q.delete();
        out_ready = 1'b0;
        send_word(32'hFFFFFFFF, 32'h1, 1'b0);
        send_word(32'hFFFFFFFF, 32'h0, 1'b0);
        in_valid = 1'b1; in_a = 32'h0; in_b = 32'h0; in_sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("t5_out_valid", {63'd0, out_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_word(32'h0, 32'h0, 1'b0);
        send_word(32'h0, 32'h0, 1'b0);
        drain();
        chk_log("t5", 4, pk(0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0), pk(32'h1, 0, 0, 0, 0),
                pk(0, 1, 0, 0, 0));

        // reset mid-operand discards the partial transaction
        send_word(32'h11111111, 32'h22222222, 1'b1);
        send_word(32'h33333333, 32'h44444444, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_outputs", {28'd0, out_sum, out_last, out_carry, out_ovf, out_zero}, 64'd0);
        @(posedge clk);
        #1;
        log_q.delete();
        send_txn(128'h00000002_00000000_00000000_00000003,
                 128'h00000001_00000000_00000000_00000005, 4'b0001);
        drain();
        chk_log("t6", 4, pk(32'hFFFFFFFE, 0, 0, 0, 0), pk(32'hFFFFFFFF, 0, 0, 0, 0),
                pk(32'hFFFFFFFF, 0, 0, 0, 0), pk(0, 1, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
